r_pair_feeder: RTL
==================

R_PAIR_FEEDER -- requirements
Module: r_pair_feeder

Interface
REQ-001 SHALL have parameter N_DELAY, default 64: lag N in samples between r_k and r_k_minus_N; legal range 2..1024.
REQ-002 SHALL take widths from package data_type: r_t is R_W bits, signed Q.R_FRAC; rho_t is RHO_W bits, signed.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin or restart a fill of the lag buffer.
REQ-006 SHALL have port in_valid, input, 1 bit: in_real, in_imag and rho_in carry a sample this cycle.
REQ-007 SHALL have ports in_real and in_imag, input, r_t each: complex input sample.
REQ-008 SHALL have port rho_in, input, rho_t: correlation weight carried with the sample.
REQ-009 SHALL have ports r_k_real and r_k_imag, output, r_t each: current sample, registered.
REQ-010 SHALL have ports r_k_minus_N_real and r_k_minus_N_imag, output, r_t each: sample from N accepted samples earlier, registered.
REQ-011 SHALL have port rho_out, output, rho_t: rho aligned to r_k.
REQ-012 SHALL have port out_valid, output, 1 bit: outputs hold a full (r_k, r_k-N) pair.
REQ-013 SHALL have port filling, output, 1 bit: high while state is FILL.
REQ-014 SHALL have port fill_cnt, output, $clog2(N_DELAY+1) bits: number of samples accepted since the last start, saturating at N_DELAY.

Function
REQ-015 SHALL implement the states IDLE, FILL and RUN, with IDLE after reset.
REQ-016 SHALL treat start as the highest priority event: in any state, start moves the block to FILL, sets wr_ptr=0 and fill_cnt=0, and discards any in_valid sample in the same cycle.
REQ-017 SHALL accept a sample only in FILL or RUN when in_valid=1 and start=0; in IDLE, in_valid is ignored.
REQ-018 SHALL, on each accepted sample, read lag memory mem[wr_ptr] (old contents, read-before-write), write {in_real, in_imag} to mem[wr_ptr], and advance wr_ptr.
REQ-019 SHALL wrap wr_ptr from N_DELAY-1 to 0.
REQ-020 SHALL increment fill_cnt on each accepted sample in FILL; when the N_DELAY-th sample is accepted, the state SHALL become RUN on the next cycle.
REQ-021 SHALL stay in RUN until start or rst; fill_cnt holds at N_DELAY in RUN.
REQ-022 SHALL drive all outputs one cycle after the accepted sample (latency 1): r_k = input sample, rho_out = rho_in.
REQ-023 SHALL set r_k_minus_N = mem read value only when the sample was accepted in RUN; for samples accepted in FILL, r_k_minus_N SHALL be 0.
REQ-024 SHALL set out_valid=1 exactly for samples accepted in RUN.
REQ-025 SHALL, in a cycle with no accepted sample (bubble, IDLE or start), drive all data outputs and rho_out to 0 and out_valid to 0 on the next cycle, so that a free-running downstream accumulator adds zero energy.
REQ-026 SHALL never emit stale memory after a restart: lag memory is not cleared, and REQ-023 zero-forcing covers the window.
REQ-027 SHALL pass data without arithmetic: no rounding and no width change.
REQ-028 SHALL hold wr_ptr and the memory contents across bubbles.

Reset
REQ-029 SHALL, on rst=1, give the next cycle: state IDLE, wr_ptr=0, fill_cnt=0, filling=0, out_valid=0, and all data outputs and rho_out at 0.
REQ-030 SHALL give rst priority over start; lag memory need not be reset.
REQ-031 SHALL, when rst is asserted mid-FILL or mid-RUN, abandon the in-flight sample: outputs are 0 on the following cycle.

Verification (N_DELAY=4)
REQ-032 SHALL cover basic lag: start, then samples re 1..8 with in_valid continuous -> outputs 1..4 with kmN=0, out_valid=0; then outputs 5..8 with kmN 1..4, out_valid=1, one cycle after each input.
REQ-033 SHALL cover bubbles: the same stream with in_valid=0 on every other cycle -> same pairs as REQ-032, with zero outputs and out_valid=0 in the bubble slots; the lag is counted in samples, not cycles.
REQ-034 SHALL cover restart in RUN: after 10 samples, start together with in_valid (sample 99) -> 99 discarded; next samples 11..14 give kmN=0; sample 15 gives kmN=11.
REQ-035 SHALL cover IDLE ignore: in_valid with data before any start -> outputs stay 0, fill_cnt=0, state IDLE.
REQ-036 SHALL cover reset mid-RUN: rst while sample 7 is presented -> next cycle all outputs 0 and IDLE; after start, kmN=0 for the first 4 samples despite stale memory.
REQ-037 SHALL cover extremes: in_real=most-negative r_t and rho_in=max rho_t -> bit-exact passthrough on r_k and, N samples later, on r_k_minus_N.

Source files
------------

// File: rtl/r_pair_feeder.sv
// Lag-pair feeder: emits each accepted sample together with the sample N_DELAY
// accepted samples earlier, zero-forced until the lag buffer has been refilled.
package data_type;
  localparam int R_W    = 16;
  localparam int R_FRAC = 14;
  localparam int RHO_W  = 18;
  typedef logic signed [R_W-1:0]   r_t;
  typedef logic signed [RHO_W-1:0] rho_t;
endpackage

module r_pair_feeder #(
  parameter int N_DELAY = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  input  data_type::r_t                    in_real,
  input  data_type::r_t                    in_imag,
  input  data_type::rho_t                  rho_in,
  output data_type::r_t                    r_k_real,
  output data_type::r_t                    r_k_imag,
  output data_type::r_t                    r_k_minus_N_real,
  output data_type::r_t                    r_k_minus_N_imag,
  output data_type::rho_t                  rho_out,
  output logic                             out_valid,
  output logic                             filling,
  output logic [$clog2(N_DELAY+1)-1:0]     fill_cnt
);
  localparam int RW = data_type::R_W;
  localparam int PW = (N_DELAY > 1) ? $clog2(N_DELAY) : 1;
  localparam int CW = $clog2(N_DELAY + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_fill_cnt;
  logic [2*RW-1:0] r_mem [N_DELAY];
  logic [2*RW-1:0] w_rd;
  logic            w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (start) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        FILL: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (r_fill_cnt == CW'(N_DELAY - 1)) w_state_nxt = RUN;
          end
        end
        RUN:     w_accept = in_valid;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
      end else if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == PW'(N_DELAY - 1)) ? '0 : r_wr_ptr + 1'b1;
        if (r_state == FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  // Lag memory is deliberately never cleared; zero-forcing in FILL hides stale data.
  assign w_rd = r_mem[r_wr_ptr];

  always_ff @(posedge clk) begin
    if (w_accept && !rst) r_mem[r_wr_ptr] <= {in_real, in_imag};
  end

  // Output stage: one cycle after acceptance, zero on any slot without a sample.
  always_ff @(posedge clk) begin
    if (rst || !w_accept) begin
      r_k_real         <= '0;
      r_k_imag         <= '0;
      r_k_minus_N_real <= '0;
      r_k_minus_N_imag <= '0;
      rho_out          <= '0;
      out_valid        <= 1'b0;
    end else begin
      r_k_real  <= in_real;
      r_k_imag  <= in_imag;
      rho_out   <= rho_in;
      out_valid <= (r_state == RUN);
      if (r_state == RUN) begin
        r_k_minus_N_real <= data_type::r_t'(w_rd[2*RW-1:RW]);
        r_k_minus_N_imag <= data_type::r_t'(w_rd[RW-1:0]);
      end else begin
        r_k_minus_N_real <= '0;
        r_k_minus_N_imag <= '0;
      end
    end
  end

  assign filling  = (r_state == FILL);
  assign fill_cnt = r_fill_cnt;

endmodule
